// File: rtl/ntt_pkg.sv
// ntt_pkg
//   Shared definitions for the NTT datapath: the scheduler state encoding,
//   default transform geometry and a helper that sizes the stage index.
//   Imported by ntt_addr_gen, ntt_stage_scheduler and the butterfly/top.
package ntt_pkg;

  localparam int NTT_N      = 256;
  localparam int NTT_LOGN   = 8;
  localparam int NTT_ADDR_W = 8;
  localparam int NTT_RD_LAT = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } ntt_state_e;

  // Width of the stage index: clog2(LOGN), but never narrower than one bit.
  function automatic int stage_width(input int logn);
    return (logn > 1) ? $clog2(logn) : 1;
  endfunction

endpackage

// File: rtl/ntt_addr_gen.sv
// ntt_addr_gen
//   Combinational address generator for one radix-2 butterfly.
//   Maps (bf_cnt, stage) to the two operand addresses and the twiddle index.
// Ports
//   bf_cnt       in   ADDR_W-1  butterfly number within the stage (0..N/2-1)
//   stage        in   SW        current stage (0..LOGN-1)
//   addr_a       out  ADDR_W    upper-wing address
//   addr_b       out  ADDR_W    lower-wing address (addr_a + span)
//   twiddle_idx  out  ADDR_W-1  twiddle ROM index
module ntt_addr_gen
  import ntt_pkg::*;
#(
  parameter int N      = NTT_N,
  parameter int LOGN   = NTT_LOGN,
  parameter int ADDR_W = NTT_ADDR_W,
  localparam int SW    = stage_width(LOGN)
) (
  input  logic [ADDR_W-2:0] bf_cnt,
  input  logic [SW-1:0]     stage,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic [ADDR_W-2:0] twiddle_idx
);

  logic [ADDR_W-1:0] bf_ext;
  logic [ADDR_W-1:0] span;
  logic [ADDR_W-1:0] mask;
  logic [ADDR_W-1:0] hi;

  // The butterfly count splits into a group number (upper bits) and an
  // offset inside the group (lower bits, below span). The group number is
  // moved up one bit to skip over the lower wing of each group, the offset
  // stays in place, and the lower wing sits exactly span words further on.
  // The twiddle exponent is the in-group offset scaled by 2^stage.
  always_comb begin
    bf_ext      = {1'b0, bf_cnt};
    span        = ADDR_W'(N >> (int'(stage) + 1));
    mask        = span - ADDR_W'(1);
    hi          = (bf_ext >> (LOGN - 1 - int'(stage))) << (LOGN - int'(stage));
    addr_a      = hi | (bf_ext & mask);
    addr_b      = addr_a + span;
    twiddle_idx = (bf_cnt & mask[ADDR_W-2:0]) << stage;
  end

endmodule

// File: rtl/ntt_stage_scheduler.sv
// ntt_stage_scheduler
//   Sequences one in-place radix-2 NTT over an N-word coefficient RAM with a
//   single butterfly unit: LOGN stages of N/2 butterflies, one per cycle,
//   with RD_LAT bubble cycles after each stage so the last write-back of a
//   stage lands before the first read of the next one.
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   start             one-cycle transform request, dropped while busy
//   busy              high from the cycle after start acceptance until done
//   done              one-cycle pulse after the final write-back
//   stage             current stage index
//   rd_en             read strobe for both RAM ports
//   rd_addr_a/b       upper/lower-wing read addresses
//   twiddle_idx       twiddle ROM index, valid with rd_en
//   bf_enable         butterfly enable, aligned with RAM read data
//   wr_en             write strobe for both RAM ports
//   wr_addr_a/b       write-back addresses, rd addresses delayed RD_LAT cycles
module ntt_stage_scheduler
  import ntt_pkg::*;
#(
  parameter int N      = NTT_N,
  parameter int LOGN   = NTT_LOGN,
  parameter int ADDR_W = NTT_ADDR_W,
  parameter int RD_LAT = NTT_RD_LAT,
  localparam int SW    = stage_width(LOGN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [SW-1:0]     stage,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr_a,
  output logic [ADDR_W-1:0] rd_addr_b,
  output logic [ADDR_W-2:0] twiddle_idx,
  output logic              bf_enable,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr_a,
  output logic [ADDR_W-1:0] wr_addr_b
);

  ntt_state_e        state;
  logic [ADDR_W-2:0] bf_cnt;
  logic [1:0]        drain_cnt;

  logic [ADDR_W-1:0] gen_addr_a;
  logic [ADDR_W-1:0] gen_addr_b;
  logic [ADDR_W-2:0] gen_twiddle;

  logic [ADDR_W-1:0] sr_a [RD_LAT];
  logic [ADDR_W-1:0] sr_b [RD_LAT];
  logic [RD_LAT-1:0] sr_en;

  ntt_addr_gen #(
    .N      (N),
    .LOGN   (LOGN),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .bf_cnt      (bf_cnt),
    .stage       (stage),
    .addr_a      (gen_addr_a),
    .addr_b      (gen_addr_b),
    .twiddle_idx (gen_twiddle)
  );

  // Read-side addresses are only meaningful while reading; holding them at
  // zero otherwise keeps the RAM/ROM inputs quiet and the write pipe clean.
  assign rd_addr_a   = rd_en ? gen_addr_a  : '0;
  assign rd_addr_b   = rd_en ? gen_addr_b  : '0;
  assign twiddle_idx = rd_en ? gen_twiddle : '0;

  // Main sequencer. busy, done and rd_en are registered alongside the state
  // so they change exactly with it. RUN walks bf_cnt through one stage and
  // wraps it to zero on the last butterfly; DRAIN idles the read port for
  // RD_LAT cycles, then either opens the next stage or finishes. A start
  // arriving anywhere but IDLE (including the DONE cycle) is simply ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bf_cnt    <= '0;
      stage     <= '0;
      drain_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state  <= RUN;
            bf_cnt <= '0;
            stage  <= '0;
            busy   <= 1'b1;
            rd_en  <= 1'b1;
          end
        end
        RUN: begin
          if (bf_cnt == '1) begin
            state     <= DRAIN;
            bf_cnt    <= '0;
            drain_cnt <= '0;
            rd_en     <= 1'b0;
          end else begin
            bf_cnt <= bf_cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (drain_cnt == 2'(RD_LAT - 1)) begin
            if (stage == SW'(LOGN - 1)) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              stage <= stage + 1'b1;
              rd_en <= 1'b1;
            end
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          stage <= '0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Write-back pipe: the read addresses and strobe are delayed by the RAM
  // read latency so the butterfly results are written back to exactly the
  // words they were read from. Reset empties the pipe, so an aborted
  // transform issues no further writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        sr_a[i] <= '0;
        sr_b[i] <= '0;
      end
      sr_en <= '0;
    end else begin
      sr_a[0]  <= rd_addr_a;
      sr_b[0]  <= rd_addr_b;
      sr_en[0] <= rd_en;
      for (int i = 1; i < RD_LAT; i++) begin
        sr_a[i]  <= sr_a[i-1];
        sr_b[i]  <= sr_b[i-1];
        sr_en[i] <= sr_en[i-1];
      end
    end
  end

  assign wr_en     = sr_en[RD_LAT-1];
  assign wr_addr_a = sr_a[RD_LAT-1];
  assign wr_addr_b = sr_b[RD_LAT-1];
  assign bf_enable = wr_en;

endmodule
